// File: rtl/vending_pkg.sv
// ============================================================================
// Module      : vending_pkg
// Description : Shared FSM state encoding and one-hot datapath select
//               constants for the vending machine controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

  // Controller states; DEPOSIT is the idle/coin-accepting state.
  typedef enum logic [2:0] {
    DEPOSIT = 3'd0,
    SERVE1  = 3'd1,
    SERVE2  = 3'd2,
    CHANGE1 = 3'd3,
    CHANGE2 = 3'd4
  } state_t;

  // One-hot value select toward the amount datapath.
  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_PRICE   = 4'b1000;
  localparam logic [3:0] SEL_NICKEL  = 4'b0100;
  localparam logic [3:0] SEL_DIME    = 4'b0010;
  localparam logic [3:0] SEL_QUARTER = 4'b0001;

  // One-hot next-amount select toward the amount datapath.
  localparam logic [2:0] NXT_HOLD = 3'b100;
  localparam logic [2:0] NXT_SUM  = 3'b010;
  localparam logic [2:0] NXT_ZERO = 3'b001;

endpackage : vending_pkg

`default_nettype wire

// File: rtl/vmc_timer.sv
// ============================================================================
// Module      : vmc_timer
// Description : Cycle counter for the serve/change wait states. Counts while
//               run is high, clears on clear, and flags expired on the cycle
//               that is the TIMEOUT-th consecutive running cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vmc_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int c_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [c_W-1:0] count_q;

  // Count running cycles; any clear or idle period restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + c_W'(1);
    end
  end

  // count_q holds the number of completed cycles, so the current cycle is
  // the TIMEOUT-th one when count_q equals TIMEOUT-1.
  assign expired = run && (count_q == c_W'(TIMEOUT - 1));

endmodule : vmc_timer

`default_nettype wire

// File: rtl/vending_machine_control.sv
// ============================================================================
// Module      : vending_machine_control
// Description : Vending machine control FSM. Steers the amount datapath on
//               coin deposit, purchase and change return, and drives the
//               serve/change handshakes with the dispenser mechanism.
//               Optional wait-state timeout enabled by macro VMC_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine_control
  import vending_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       dispense,
  input  logic       done,
  input  logic       enough,
  input  logic       zero,
  output logic [3:0] selval,
  output logic [2:0] selnext,
  output logic       sub,
  output logic       serve,
  output logic       change,
  output logic       fault
);

  state_t state_q;
  state_t state_d;
  logic   serve_q;
  logic   change_q;
  logic   w_leave;
  logic   w_expired;
  logic   w_timeout;

  // Handshake-driven exit from the current wait state (no timeout involved).
  always_comb begin
    w_leave = 1'b0;
    case (state_q)
      SERVE1:  w_leave = done;
      SERVE2:  w_leave = !done;
      CHANGE1: w_leave = done;
      CHANGE2: w_leave = !done;
      default: w_leave = 1'b0;
    endcase
  end

`ifdef VMC_TIMEOUT_EN
  logic fault_q;

  vmc_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_leave || w_expired),
    .run     (state_q != DEPOSIT),
    .expired (w_expired)
  );

  assign fault = fault_q;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT;
  assign w_expired        = 1'b0;
  assign fault            = 1'b0;
`endif

  // A real handshake transition in the expiry cycle takes precedence.
  assign w_timeout = w_expired && !w_leave;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEPOSIT: begin
        if (!quarter && !dime && !nickel && dispense && enough) begin
          state_d = SERVE1;
        end
      end
      SERVE1:  if (done)  state_d = SERVE2;
      SERVE2:  if (!done) state_d = zero ? DEPOSIT : CHANGE1;
      CHANGE1: if (done)  state_d = CHANGE2;
      CHANGE2: if (!done) state_d = zero ? DEPOSIT : CHANGE1;
      default: state_d = DEPOSIT;
    endcase
    if (w_timeout) begin
      state_d = DEPOSIT;
    end
  end

  // State register with registered Moore handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DEPOSIT;
      serve_q  <= 1'b0;
      change_q <= 1'b0;
`ifdef VMC_TIMEOUT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      serve_q  <= (state_d == SERVE1);
      change_q <= (state_d == CHANGE1);
`ifdef VMC_TIMEOUT_EN
      fault_q  <= w_timeout;
`endif
    end
  end

  assign serve  = serve_q;
  assign change = change_q;

  // Datapath steering: coin add, price subtract, nickel refund, reset clear.
  always_comb begin
    selval  = SEL_NONE;
    selnext = NXT_HOLD;
    sub     = 1'b0;
    if (rst) begin
      selnext = NXT_ZERO;
    end else begin
      case (state_q)
        DEPOSIT: begin
          if (quarter) begin
            selval  = SEL_QUARTER;
            selnext = NXT_SUM;
          end else if (dime) begin
            selval  = SEL_DIME;
            selnext = NXT_SUM;
          end else if (nickel) begin
            selval  = SEL_NICKEL;
            selnext = NXT_SUM;
          end else if (dispense && enough) begin
            selval  = SEL_PRICE;
            selnext = NXT_SUM;
            sub     = 1'b1;
          end
        end
        CHANGE1: begin
          if (done) begin
            selval  = SEL_NICKEL;
            selnext = NXT_SUM;
            sub     = 1'b1;
          end
        end
        default: begin
          selval  = SEL_NONE;
          selnext = NXT_HOLD;
          sub     = 1'b0;
        end
      endcase
    end
  end

endmodule : vending_machine_control

`default_nettype wire

// File: doc/vending_machine_control.md
VENDING_MACHINE_CONTROL -- requirements
Module: vending_machine_control

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles to wait for each edge of done in a serve/change state (used only with VMC_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 nickel, dime, quarter  input  1 each  one-cycle coin pulses, already synchronized to clk.
REQ-005 dispense  input  1  level request to vend.
REQ-006 done  input  1  level acknowledge from the dispenser/changer mechanism.
REQ-007 enough, zero  input  1 each  datapath flags: amount >= price, amount == 0.
REQ-008 selval  output  4  one-hot datapath value select: bit3=price, bit2=nickel, bit1=dime, bit0=quarter.
REQ-009 selnext  output  3  one-hot datapath next-amount select: bit2=hold, bit1=sum, bit0=zero.
REQ-010 sub  output  1  datapath subtract (1) / add (0).
REQ-011 serve, change  output  1 each  dispense-drink / eject-one-nickel commands.
REQ-012 fault  output  1  one-cycle timeout pulse (VMC_TIMEOUT_EN only).

Function
REQ-013 The FSM SHALL have states DEPOSIT, SERVE1, SERVE2, CHANGE1, CHANGE2.
REQ-014 selval/selnext/sub SHALL be combinational from state and inputs; serve/change/fault SHALL be registered (Moore).
REQ-015 Default outputs: selnext=100 (hold), selval=0000, sub=0.
REQ-016 DEPOSIT, coin pulse: selval = coin bit, selnext=010, sub=0; amount updates at the same clk edge; state stays DEPOSIT.
REQ-017 Simultaneous coins: priority quarter > dime > nickel; lower-priority coins in that cycle are dropped.
REQ-018 DEPOSIT, no coin, dispense & enough: selval=1000, selnext=010, sub=1, next state SERVE1.
REQ-019 A coin in the same cycle as dispense SHALL win; dispense is re-evaluated next cycle.
REQ-020 DEPOSIT, dispense & !enough: no action, hold.
REQ-021 SERVE1: serve=1; on done=1, go to SERVE2.
REQ-022 SERVE2: serve=0; on done=0, go to DEPOSIT if zero, else CHANGE1.
REQ-023 CHANGE1: change=1; on done=1, selval=0100, selnext=010, sub=1 (subtract one nickel), go to CHANGE2.
REQ-024 CHANGE2: change=0; on done=0, go to DEPOSIT if zero, else CHANGE1.
REQ-025 Coins and dispense SHALL be ignored outside DEPOSIT.

Reset
REQ-026 While rst=1: selnext=001 (clear amount), selval=0000, sub=0, and all coin and dispense inputs ignored.
REQ-027 Reset values: state=DEPOSIT, serve=0, change=0, fault=0, timer=0.
REQ-028 Reset asserted mid-serve or mid-change SHALL abort at the next edge and clear the amount, with no change returned.

Configuration
REQ-029 Macro VMC_TIMEOUT_EN, defined: the timer counts cycles spent in SERVE1/SERVE2/CHANGE1/CHANGE2 and clears on every state change.
REQ-030 VMC_TIMEOUT_EN, defined: when the count reaches TIMEOUT with no transition, fault pulses 1 cycle and state returns to DEPOSIT with the amount held.
REQ-031 VMC_TIMEOUT_EN undefined: no timer logic, fault tied 0, the FSM waits indefinitely, and the TIMEOUT parameter is unused.

Structure
REQ-032 Shared package vending_pkg SHALL hold the state enum and the one-hot constants SEL_PRICE/SEL_NICKEL/SEL_DIME/SEL_QUARTER and NXT_HOLD/NXT_SUM/NXT_ZERO.
REQ-033 The timeout counter SHALL be sub-module vmc_timer (inputs clk, rst, clear, run; output expired), instantiated only under VMC_TIMEOUT_EN.

Verification
REQ-034 rst=1 for 2 cycles -> selnext=001 both cycles; after release state=DEPOSIT and serve=change=fault=0.
REQ-035 DEPOSIT, quarter=dime=1 same cycle -> selval=0001, selnext=010, sub=0, and no dime accounted.
REQ-036 dispense=1 & enough=1 -> selval=1000, sub=1, selnext=010 that cycle; serve=1 next cycle. Then done 1->0 with zero=1 -> back to DEPOSIT with change never asserted.
REQ-037 After serve with zero=0 for 2 nickel rounds -> change pulses twice, each done=1 cycle shows selval=0100, sub=1; zero=1 after the second round -> DEPOSIT.
REQ-038 dispense=1 & enough=0 for 10 cycles -> selnext=100 throughout and serve stays 0.
REQ-039 With VMC_TIMEOUT_EN and TIMEOUT=8: SERVE1 with done held 0 -> fault=1 on exactly the 8th-cycle boundary, then DEPOSIT. Without the macro, the same stimulus leaves the FSM in SERVE1 indefinitely.
